// File: rtl/uwire_pkg.sv
// Shared definitions for the uwire frame unloader: word width and FSM state type.
package uwire_pkg;

  localparam int UWIRE_WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } uwire_state_t;

endpackage

// File: rtl/uwire_unloader.sv
// Collects NUM_WORDS received words into a frame (first word in the top slot) and
// publishes the whole frame on q at once; a stalled partial frame is dropped after a timeout.
module uwire_unloader
  import uwire_pkg::*;
#(
  parameter int NUM_WORDS      = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [UWIRE_WORD_W-1:0]                  d,
  input  logic                                     valid,
  output logic [NUM_WORDS-1:0][UWIRE_WORD_W-1:0]   q,
  output logic                                     done,
  output logic                                     busy,
  output logic                                     timeout_err
);

  localparam int WL     = $clog2(NUM_WORDS + 1) + 1;
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  localparam logic [WL-1:0] WL_INIT = WL'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  uwire_state_t                             r_state;
  uwire_state_t                             w_state_nxt;
  logic [WL-1:0]                            r_words_left;
  logic [WL-1:0]                            w_words_left_nxt;
  logic [TW-1:0]                            r_to_cnt;
  logic [TW-1:0]                            w_to_cnt_nxt;
  logic [NUM_WORDS-1:0][UWIRE_WORD_W-1:0]   r_buf;
  logic [NUM_WORDS-1:0][UWIRE_WORD_W-1:0]   w_buf_nxt;
  logic [WL-1:0]                            w_slot;
  logic                                     w_complete;
  logic                                     w_drop;

  always_comb begin
    w_state_nxt      = r_state;
    w_words_left_nxt = r_words_left;
    w_to_cnt_nxt     = r_to_cnt;
    w_complete       = 1'b0;
    w_drop           = 1'b0;
    w_slot           = (r_state == IDLE) ? WL_INIT : (r_words_left - WL'(1));

    // Merged view of the buffer so the completing edge can load q with the final word included.
    w_buf_nxt = r_buf;
    if (valid) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (w_slot == WL'(i)) w_buf_nxt[i] = d;
      end
    end

    case (r_state)
      IDLE: begin
        if (valid) begin
          w_to_cnt_nxt = '0;
          if (NUM_WORDS == 1) begin
            w_complete       = 1'b1;
            w_words_left_nxt = '0;
          end else begin
            w_state_nxt      = RECV;
            w_words_left_nxt = WL_INIT;
          end
        end
      end
      RECV: begin
        if (valid) begin
          w_to_cnt_nxt     = '0;
          w_words_left_nxt = r_words_left - WL'(1);
          if (r_words_left == WL'(1)) begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (r_to_cnt == TO_LAST)) begin
          w_drop           = 1'b1;
          w_state_nxt      = IDLE;
          w_to_cnt_nxt     = '0;
          w_words_left_nxt = '0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_words_left <= '0;
      r_to_cnt     <= '0;
      q            <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_words_left <= w_words_left_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      done         <= w_complete;
      busy         <= (w_state_nxt == RECV);
      timeout_err  <= w_drop;
      if (w_complete) q <= w_buf_nxt;
    end
  end

  // Assembly buffer carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    r_buf <= w_buf_nxt;
  end

endmodule

// File: tb/tb_uwire_unloader.sv
// Directed bench for uwire_unloader with three frame sizes (3 words/8-cycle timeout, 1 word, 2 words).
module tb_uwire_unloader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst3, valid3, done3, busy3, terr3;
  logic [31:0]       d3;
  logic [2:0][31:0]  q3;
  logic              rst1, valid1, done1, busy1, terr1;
  logic [31:0]       d1;
  logic [0:0][31:0]  q1;
  logic              rst2, valid2, done2, busy2, terr2;
  logic [31:0]       d2;
  logic [1:0][31:0]  q2;

  int n_chk = 0;
  int n_err = 0;

  uwire_unloader #(.NUM_WORDS(3), .TIMEOUT_CYCLES(8)) dut3 (
    .clk(clk), .rst(rst3), .d(d3), .valid(valid3),
    .q(q3), .done(done3), .busy(busy3), .timeout_err(terr3));

  uwire_unloader #(.NUM_WORDS(1)) dut1 (
    .clk(clk), .rst(rst1), .d(d1), .valid(valid1),
    .q(q1), .done(done1), .busy(busy1), .timeout_err(terr1));

  uwire_unloader #(.NUM_WORDS(2)) dut2 (
    .clk(clk), .rst(rst2), .d(d2), .valid(valid2),
    .q(q2), .done(done2), .busy(busy2), .timeout_err(terr2));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst3 = 1'b1; valid3 = 1'b0; d3 = '0;
    rst1 = 1'b1; valid1 = 1'b0; d1 = '0;
    rst2 = 1'b1; valid2 = 1'b0; d2 = '0;
    tick(); tick();
    rst3 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    chk("rst_q3",    q3,    96'h0);
    chk("rst_done3", done3, 1'b0);
    chk("rst_busy3", busy3, 1'b0);
    chk("rst_terr3", terr3, 1'b0);
    chk("rst_q1",    q1,    32'h0);

    // Basic 3-word frame
    valid3 = 1'b1; d3 = 32'hAAAA_0001; tick();
    chk("f1_busy", busy3, 1'b1);
    chk("f1_done_early", done3, 1'b0);
    d3 = 32'hBBBB_0002; tick();
    d3 = 32'hCCCC_0003; tick();
    valid3 = 1'b0;
    chk("f1_done", done3, 1'b1);
    chk("f1_q", q3, {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003});
    chk("f1_busy_after", busy3, 1'b0);
    tick();
    chk("f1_done_pulse", done3, 1'b0);

    // Two words then 8 idle cycles -> timeout
    valid3 = 1'b1; d3 = 32'h1111_1111; tick();
    d3 = 32'h2222_2222; tick();
    valid3 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_not_yet", terr3, 1'b0);
    chk("to_busy_wait", busy3, 1'b1);
    tick();
    chk("to_fire", terr3, 1'b1);
    chk("to_no_done", done3, 1'b0);
    chk("to_busy_low", busy3, 1'b0);
    chk("to_q_kept", q3, {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003});
    tick();
    chk("to_pulse", terr3, 1'b0);

    // Word arriving in the would-fire cycle is accepted
    valid3 = 1'b1; d3 = 32'h0000_00A1; tick();
    valid3 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    valid3 = 1'b1; d3 = 32'h0000_00B2; tick();
    chk("late_no_terr", terr3, 1'b0);
    chk("late_busy", busy3, 1'b1);
    d3 = 32'h0000_00C3; tick();
    valid3 = 1'b0;
    chk("late_done", done3, 1'b1);
    chk("late_no_terr2", terr3, 1'b0);
    chk("late_q", q3, {32'h0000_00A1, 32'h0000_00B2, 32'h0000_00C3});
    tick();

    // Reset mid-frame, with a coincident valid, then a clean frame
    valid3 = 1'b1; d3 = 32'h5555_5555; tick();
    rst3 = 1'b1; d3 = 32'h6666_6666; tick();
    rst3 = 1'b0; valid3 = 1'b0;
    chk("rst_mid_q", q3, 96'h0);
    chk("rst_mid_busy", busy3, 1'b0);
    chk("rst_mid_done", done3, 1'b0);
    tick();
    chk("rst_mid_done2", done3, 1'b0);
    chk("rst_mid_terr", terr3, 1'b0);
    valid3 = 1'b1; d3 = 32'hDDDD_0004; tick();
    chk("rst_q_d", q3, 96'h0);
    d3 = 32'hEEEE_0005; tick();
    chk("rst_q_e", q3, 96'h0);
    chk("rst_done_e", done3, 1'b0);
    d3 = 32'hFFFF_0006; tick();
    valid3 = 1'b0;
    chk("rst_done_f", done3, 1'b1);
    chk("rst_q_f", q3, {32'hDDDD_0004, 32'hEEEE_0005, 32'hFFFF_0006});
    tick();
    chk("rst_done_once", done3, 1'b0);

    // Single-word frames back to back
    valid1 = 1'b1; d1 = 32'hDEAD_BEEF; tick();
    chk("n1_done_a", done1, 1'b1);
    chk("n1_busy_a", busy1, 1'b0);
    tick();
    valid1 = 1'b0;
    chk("n1_done_b", done1, 1'b1);
    chk("n1_q", q1, 32'hDEAD_BEEF);
    tick();
    chk("n1_done_end", done1, 1'b0);
    chk("n1_terr", terr1, 1'b0);

    // Two-word frame followed immediately by a new frame
    valid2 = 1'b1; d2 = 32'h1234_5678; tick();
    d2 = 32'h9ABC_DEF0; tick();
    chk("n2_done", done2, 1'b1);
    chk("n2_q", q2, {32'h1234_5678, 32'h9ABC_DEF0});
    chk("n2_busy_y", busy2, 1'b0);
    d2 = 32'h0BAD_F00D; tick();
    valid2 = 1'b0;
    chk("n2_busy_p", busy2, 1'b1);
    chk("n2_done_p", done2, 1'b0);
    chk("n2_q_held", q2, {32'h1234_5678, 32'h9ABC_DEF0});
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/uwire_unloader.md
UWIRE_UNLOADER -- requirements
Module: uwire_unloader

Interface
REQ-001 Parameter NUM_WORDS, default 1: number of 32-bit words per frame; legal range >= 1.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: idle cycles allowed between words of one frame; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 d  input  32  received word from the uwire receiver.
REQ-006 valid  input  1  one-cycle strobe; d is valid in this cycle.
REQ-007 q  output  [NUM_WORDS-1:0][31:0]  last completed frame, registered.
REQ-008 done  output  1  one-cycle pulse; q has just been updated with a complete frame.
REQ-009 busy  output  1  high while a frame is partially received.
REQ-010 timeout_err  output  1  one-cycle pulse; a partial frame was discarded.

Function
REQ-011 States shall be IDLE and RECV only.
REQ-012 Word order shall mirror the transmit side: the first word of a frame lands in q[NUM_WORDS-1], and the last word lands in q[0].
REQ-013 Words shall be assembled in an internal buffer; q shall change only on frame completion, with all NUM_WORDS words updated on the same edge.
REQ-014 Counter words_left shall have width $clog2(NUM_WORDS+1)+1 and shall index buffer slot words_left-1.
REQ-015 IDLE with valid: store d at slot NUM_WORDS-1, set words_left to NUM_WORDS-1, clear the timeout counter, and go to RECV; if NUM_WORDS==1, complete the frame instead (REQ-017).
REQ-016 RECV with valid: store d at slot words_left-1, decrement words_left, and clear the timeout counter.
REQ-017 Completion is the edge that accepts the final word: q loads the buffer with that word merged in, done pulses high for the following cycle, and the state returns to IDLE.
REQ-018 Latency from the final valid to done high shall be 1 cycle; q shall be valid in the same cycle as done.
REQ-019 A valid in the cycle immediately after completion shall start a new frame; there shall be no dead cycle.
REQ-020 RECV without valid: increment the timeout counter; when it reaches TIMEOUT_CYCLES-1, discard the buffer, pulse timeout_err for one cycle, return to IDLE, and leave q unchanged.
REQ-021 valid in the same cycle the timeout would fire: the word shall be accepted and timeout_err shall not pulse.
REQ-022 With TIMEOUT_CYCLES==0, RECV shall wait indefinitely.
REQ-023 busy shall equal (state==RECV), registered.
REQ-024 done and timeout_err shall never be high in the same cycle.
REQ-025 valid in IDLE is never an error; there is no overflow condition.

Reset
REQ-026 rst shall force state IDLE, q all zeros, done 0, busy 0, timeout_err 0, words_left 0, and timeout counter 0.
REQ-027 rst during RECV shall discard the partial frame without pulsing done or timeout_err.
REQ-028 rst shall take precedence over a coincident valid.

Structure
REQ-029 Package uwire_pkg shall hold UWIRE_WORD_W=32 and the IDLE/RECV state enum typedef.
REQ-030 Flat module, no sub-modules; the timeout counter is inline, and its width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Verification
REQ-031 NUM_WORDS=3: valid with d=A,B,C on consecutive cycles -> done high 1 cycle after C; q[2]=A, q[1]=B, q[0]=C.
REQ-032 NUM_WORDS=3, TIMEOUT_CYCLES=8: words A,B, then 8 idle cycles -> timeout_err pulse; q keeps the previous frame; busy low afterwards.
REQ-033 NUM_WORDS=3, TIMEOUT_CYCLES=8: A, then 7 idle cycles, then B in the would-fire cycle, then C -> no timeout_err; done pulses; q={A,B,C}.
REQ-034 NUM_WORDS=1: valid d=0xDEADBEEF twice back-to-back -> done high two consecutive cycles; q[0]=0xDEADBEEF.
REQ-035 NUM_WORDS=3: A, then rst, then D,E,F -> no done for A; one done after F; q={D,E,F}; q reads 0 between rst and completion.
REQ-036 NUM_WORDS=2: frame X,Y followed by P in the next cycle -> done after Y, with busy high in the cycle after P.
